// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, image window geometry, the OFF/ON
// display state and the per-pixel record carried down the output pipeline.
package vga_pkg;

   localparam logic [9:0] H_VISIBLE = 10'd640;
   localparam logic [9:0] H_FRONT   = 10'd16;
   localparam logic [9:0] H_SYNC    = 10'd96;
   localparam logic [9:0] H_BACK    = 10'd48;
   localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam logic [9:0] V_VISIBLE = 10'd480;
   localparam logic [9:0] V_FRONT   = 10'd10;
   localparam logic [9:0] V_SYNC    = 10'd2;
   localparam logic [9:0] V_BACK    = 10'd33;
   localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] IMG_X0 = 10'd192;
   localparam logic [9:0] IMG_Y0 = 10'd112;
   localparam logic [9:0] IMG_W  = 10'd256;
   localparam logic [9:0] IMG_H  = 10'd256;

   typedef enum logic {OFF = 1'b0, ON = 1'b1} vga_state_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank_n;
      logic win;
      logic ring;
      logic last;
   } vga_pix_t;

   // Idle pipeline contents: syncs deasserted (high), everything else off.
   localparam vga_pix_t PIX_IDLE = '{hsync: 1'b1, vsync: 1'b1, default: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Free-running 800x525 raster counters with raw (unpipelined) sync and
// blank decode for the current counter position.
module vga_timing
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       blank_n_raw
);

   localparam logic [9:0] HS_START = H_VISIBLE + H_FRONT;
   localparam logic [9:0] HS_END   = HS_START + H_SYNC;
   localparam logic [9:0] VS_START = V_VISIBLE + V_FRONT;
   localparam logic [9:0] VS_END   = VS_START + V_SYNC;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_TOTAL - 10'd1) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   assign hsync_raw   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
   assign vsync_raw   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
   assign blank_n_raw = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);

endmodule

// File: rtl/vga_image_reader.sv
// Streams a 256x256 grayscale image from a 1-cycle-latency memory onto a
// 640x480 VGA raster. Optional 0xFF border ring: define VGA_BORDER_EN.
module vga_image_reader
   import vga_pkg::*;
#(
   parameter int ADDR_W = 18,
   parameter int PIX_W  = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic              hsync,
   output logic              vsync,
   output logic              blank_n,
   output logic [7:0]        red,
   output logic [7:0]        green,
   output logic [7:0]        blue,
   output logic              frame_done
);

   logic [9:0] h_cnt, v_cnt;
   logic       hsync_raw, vsync_raw, blank_n_raw;

   vga_timing u_timing (
      .clk        (clk),
      .reset      (reset),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .hsync_raw  (hsync_raw),
      .vsync_raw  (vsync_raw),
      .blank_n_raw(blank_n_raw)
   );

   // Window decode and address generation
   logic       in_win, ring_hit, frame_start, last_pix;
   logic [7:0] dx, dy;

   assign in_win      = (h_cnt >= IMG_X0) && (h_cnt < IMG_X0 + IMG_W) &&
                        (v_cnt >= IMG_Y0) && (v_cnt < IMG_Y0 + IMG_H);
   assign dx          = 8'(h_cnt - IMG_X0);
   assign dy          = 8'(v_cnt - IMG_Y0);
   assign frame_start = (h_cnt == '0) && (v_cnt == '0);
   assign last_pix    = (h_cnt == IMG_X0 + IMG_W - 10'd1) &&
                        (v_cnt == IMG_Y0 + IMG_H - 10'd1);

`ifdef VGA_BORDER_EN
   logic x_edge, y_edge, x_span, y_span;
   assign x_edge   = (h_cnt == IMG_X0 - 10'd1) || (h_cnt == IMG_X0 + IMG_W);
   assign y_edge   = (v_cnt == IMG_Y0 - 10'd1) || (v_cnt == IMG_Y0 + IMG_H);
   assign x_span   = (h_cnt >= IMG_X0 - 10'd1) && (h_cnt <= IMG_X0 + IMG_W);
   assign y_span   = (v_cnt >= IMG_Y0 - 10'd1) && (v_cnt <= IMG_Y0 + IMG_H);
   assign ring_hit = (x_edge && y_span) || (y_edge && x_span);
`else
   assign ring_hit = 1'b0;
`endif

   // Address only advances inside the window, so the wrap after the last
   // pixel issues no further read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      mem_addr <= '0;
      else if (in_win) mem_addr <= ADDR_W'({dy, dx});
   end

   // Display state: sampled only at frame start
   vga_state_t state, state_nxt;
   logic       is_on;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= OFF;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (frame_start) state_nxt = enable ? ON : OFF;
   end

   always_comb begin
      is_on = (state == ON);
   end

   // Two-stage pipeline keeps syncs aligned with the memory's read data
   vga_pix_t         pix_s0;
   vga_pix_t [2:1]   pix_pipe;

   always_comb begin
      pix_s0         = PIX_IDLE;
      pix_s0.hsync   = hsync_raw;
      pix_s0.vsync   = vsync_raw;
      pix_s0.blank_n = blank_n_raw;
      pix_s0.win     = is_on && in_win;
      pix_s0.ring    = is_on && ring_hit;
      pix_s0.last    = is_on && last_pix;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_pipe[1] <= PIX_IDLE;
         pix_pipe[2] <= PIX_IDLE;
      end else begin
         pix_pipe[1] <= pix_s0;
         pix_pipe[2] <= pix_pipe[1];
      end
   end

   logic [7:0] pix_val;

   always_comb begin
      pix_val = '0;
      if (pix_pipe[2].win)       pix_val = 8'(mem_rdata);
      else if (pix_pipe[2].ring) pix_val = 8'hFF;
   end

   assign hsync      = pix_pipe[2].hsync;
   assign vsync      = pix_pipe[2].vsync;
   assign blank_n    = pix_pipe[2].blank_n;
   assign frame_done = pix_pipe[2].last;
   assign red        = pix_val;
   assign green      = pix_val;
   assign blue       = pix_val;

endmodule

// File: tb/tb_vga_image_reader.sv
// Self-checking bench for vga_image_reader: cycle-count reference model,
// pixel vector table, sync timing measurement and mid-frame reset.
module tb_vga_image_reader;

   localparam int HT    = 800;
   localparam int VT    = 525;
   localparam int FRAME = HT * VT;

`ifdef VGA_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [17:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic        hsync, vsync, blank_n, frame_done;
   logic [7:0]  red, green, blue;

   always #20 clk = ~clk;

   // Synchronous image memory: pixel value = low address byte
   always @(posedge clk) mem_rdata <= mem_addr[7:0];

   vga_image_reader #(.ADDR_W(18), .PIX_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .hsync     (hsync),
      .vsync     (vsync),
      .blank_n   (blank_n),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .frame_done(frame_done)
   );

   typedef struct {
      int         f;
      int         x;
      int         y;
      logic [7:0] col;
      logic       bl;
      logic       hs;
      logic       vs;
   } vec_t;

   vec_t        vecs[$];
   bit          hit[0:31];
   int          tests = 0;
   int          fails = 0;
   int          printed = 0;
   int          n = 0;
   int          epoch = 0;
   bit          fon[0:3];
   int          fd_cnt[0:3];
   logic [17:0] exp_addr = '0;
   logic        prev_hs = 1'b1, prev_vs = 1'b1;
   int          hs_fall = -1, vs_fall = -1;
   int          hs_per = -1, hs_low = -1, vs_per = -1, vs_low = -1;

   function automatic bit in_win(int h, int v);
      return h >= 192 && h < 448 && v >= 112 && v < 368;
   endfunction

   function automatic bit in_ring(int h, int v);
      return ((h == 191 || h == 448) && v >= 111 && v <= 368) ||
             ((v == 111 || v == 368) && h >= 191 && h <= 448);
   endfunction

   task automatic fail_msg(input string s);
      fails++;
      if (printed < 40) $display("FAIL %s", s);
      printed++;
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) fail_msg($sformatf("%s got %0d expected %0d", name, act, exp));
   endtask

   task automatic check_reset_vals(input string name);
      tests++;
      if ({hsync, vsync, blank_n, red, green, blue, frame_done, mem_addr} !==
          {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 18'h0})
         fail_msg($sformatf("%s got hs=%b vs=%b bl=%b rgb=%h/%h/%h fd=%b addr=%h expected hs=1 vs=1 bl=0 rgb=0 fd=0 addr=0",
                            name, hsync, vsync, blank_n, red, green, blue, frame_done, mem_addr));
   endtask

   task automatic check();
      int         p, h, v, f;
      logic       e_hs, e_vs, e_bl, e_fd;
      logic [7:0] e_col;
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fd = 1'b0; e_col = 8'h00;
      h = 0; v = 0; f = 0;
      if (n >= 1) begin
         p = n - 1;
         if (in_win(p % HT, (p / HT) % VT))
            exp_addr = 18'(((p / HT) % VT - 112) * 256 + (p % HT - 192));
      end
      if (n >= 2) begin
         p = n - 2; h = p % HT; v = (p / HT) % VT; f = p / FRAME;
         e_hs = !(h >= 656 && h < 752);
         e_vs = !(v >= 490 && v < 492);
         e_bl = (h < 640) && (v < 480);
         if (fon[f] && in_win(h, v))               e_col = 8'(h - 192);
         else if (BORDER && fon[f] && in_ring(h, v)) e_col = 8'hFF;
         e_fd = fon[f] && h == 447 && v == 367;
         if (frame_done && epoch == 0) fd_cnt[f]++;
      end
      tests++;
      if ({hsync, vsync, blank_n, red, green, blue, frame_done, mem_addr} !==
          {e_hs, e_vs, e_bl, e_col, e_col, e_col, e_fd, exp_addr})
         fail_msg($sformatf("pixel n=%0d (%0d,%0d) got hs=%b vs=%b bl=%b rgb=%h/%h/%h fd=%b addr=%h expected hs=%b vs=%b bl=%b rgb=%h fd=%b addr=%h",
                            n, h, v, hsync, vsync, blank_n, red, green, blue, frame_done, mem_addr,
                            e_hs, e_vs, e_bl, e_col, e_fd, exp_addr));
      if (n >= 2 && epoch == 0) begin
         for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].f == f && vecs[i].x == h && vecs[i].y == v) begin
               hit[i] = 1'b1;
               tests++;
               if ({red, blank_n, hsync, vsync} !== {vecs[i].col, vecs[i].bl, vecs[i].hs, vecs[i].vs})
                  fail_msg($sformatf("vec%0d f%0d (%0d,%0d) got col=%h bl=%b hs=%b vs=%b expected col=%h bl=%b hs=%b vs=%b",
                                     i, f, h, v, red, blank_n, hsync, vsync,
                                     vecs[i].col, vecs[i].bl, vecs[i].hs, vecs[i].vs));
            end
         end
      end
      if (prev_hs && !hsync) begin
         if (hs_fall >= 0 && hs_per < 0) hs_per = n - hs_fall;
         hs_fall = n;
      end
      if (!prev_hs && hsync && hs_fall >= 0 && hs_low < 0) hs_low = n - hs_fall;
      if (prev_vs && !vsync) begin
         if (vs_fall >= 0 && vs_per < 0) vs_per = n - vs_fall;
         vs_fall = n;
      end
      if (!prev_vs && vsync && vs_fall >= 0 && vs_low < 0) vs_low = n - vs_fall;
      prev_hs = hsync;
      prev_vs = vsync;
   endtask

   // Latches the frame's display decision from enable at the frame-start cycle
   task automatic step();
      if (n % FRAME == 0 && n / FRAME < 4) fon[n / FRAME] = enable;
      @(negedge clk);
      n++;
      check();
   endtask

   initial begin
      vecs.push_back('{0, 192, 112, 8'h00, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{0, 300, 300, 8'h00, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{0, 700,  10, 8'h00, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1,   0,   0, 8'h00, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{1, 192, 112, 8'h00, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{1, 193, 112, 8'h01, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{1, 320, 250, 8'h80, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{1, 447, 367, 8'hFF, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{1, 191, 200, BORDER ? 8'hFF : 8'h00, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{1, 448, 111, BORDER ? 8'hFF : 8'h00, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{1, 192, 111, BORDER ? 8'hFF : 8'h00, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{1, 447, 368, BORDER ? 8'hFF : 8'h00, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{1, 100, 491, 8'h00, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{2, 300, 120, 8'h00, 1'b1, 1'b1, 1'b1});
      for (int i = 0; i < 4; i++) begin fon[i] = 1'b0; fd_cnt[i] = 0; end

      repeat (3) @(negedge clk);
      check_reset_vals("reset_state");
      reset = 1'b1;
      n = 0;

      // Frame 0: enable rises at v=200 (frame stays black); frame 1: random
      // mid-frame toggles then a drop at v=200; frame 2 runs black.
      while (n < 2 * FRAME + 150 * HT + 300) begin
         step();
         if (n == 200 * HT)                               enable = 1'b1;
         else if (n == FRAME + 199 * HT)                  enable = 1'b1;
         else if (n == FRAME + 200 * HT)                  enable = 1'b0;
         else if (n > FRAME && n < FRAME + 199 * HT &&
                  $urandom_range(0, 499) == 0)            enable = ~enable;
      end

      // Mid-frame reset at (300,150): must act without waiting for an edge
      reset = 1'b0;
      #1 check_reset_vals("async_reset");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_reset_vals("reset_hold");
      end
      reset    = 1'b1;
      epoch    = 1;
      n        = 0;
      exp_addr = '0;
      enable   = 1'b1;
      for (int i = 0; i < 4; i++) fon[i] = 1'b0;
      while (n < 3 * HT) step();

      check_int("hsync_period", hs_per, 800);
      check_int("hsync_low", hs_low, 96);
      check_int("vsync_period", vs_per, FRAME);
      check_int("vsync_low", vs_low, 1600);
      check_int("frame_done_f0", fd_cnt[0], 0);
      check_int("frame_done_f1", fd_cnt[1], 1);
      check_int("frame_done_f2", fd_cnt[2], 0);
      for (int i = 0; i < vecs.size(); i++) check_int($sformatf("vec%0d_reached", i), int'(hit[i]), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
